// File: rtl/alu_pkg.sv
// Shared types for the ALU sharing controller: op encoding, NZVC flag layout and FSM states.
package alu_pkg;

    localparam int unsigned WIDTH   = 64;
    localparam int unsigned CNTRL_W = 3;
    localparam int unsigned FLAGS_W = 4;

    typedef enum logic [CNTRL_W-1:0] {
        OP_PASSB = 3'b000,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_AND   = 3'b100,
        OP_OR    = 3'b101,
        OP_XOR   = 3'b110
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } nzvc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer flips to the loser after each granted advance.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid_i,
    input  logic       advance_i,
    output logic [1:0] grant_c_o
);

    logic rr_ptr_q;
    logic rr_ptr_d;

    // Lone requester always wins; a tie goes to the pointed-at requester.
    always_comb begin
        grant_c_o = 2'b00;
        case (valid_i)
            2'b01:   grant_c_o = 2'b01;
            2'b10:   grant_c_o = 2'b10;
            2'b11:   grant_c_o = rr_ptr_q ? 2'b10 : 2'b01;
            default: grant_c_o = 2'b00;
        endcase
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance_i && (grant_c_o != 2'b00)) begin
            rr_ptr_d = grant_c_o[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one ALU between two requesters: accept, one execute cycle, then hold the
// response until the owner takes it. Maintains the architectural NZVC register.
module alu_share_ctrl #(
    parameter int unsigned WIDTH   = alu_pkg::WIDTH,
    parameter int unsigned CNTRL_W = alu_pkg::CNTRL_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic [CNTRL_W-1:0] req0_cntrl,
    input  logic               req0_setflags,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    input  logic [CNTRL_W-1:0] req1_cntrl,
    input  logic               req1_setflags,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic [3:0]         rsp_flags,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [CNTRL_W-1:0] alu_cntrl,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_negative,
    input  logic               alu_zero,
    input  logic               alu_overflow,
    input  logic               alu_carry,
    output logic [3:0]         flags,
    output logic               busy
);

    import alu_pkg::*;

    ctrl_state_t        state_q,      state_d;
    logic               owner_q,      owner_d;
    logic               setflags_q,   setflags_d;
    logic [WIDTH-1:0]   alu_a_q,      alu_a_d;
    logic [WIDTH-1:0]   alu_b_q,      alu_b_d;
    logic [CNTRL_W-1:0] alu_cntrl_q,  alu_cntrl_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    nzvc_t              rsp_flags_q,  rsp_flags_d;
    nzvc_t              flags_q,      flags_d;
    logic               rsp0_valid_q, rsp0_valid_d;
    logic               rsp1_valid_q, rsp1_valid_d;
    logic               busy_q,       busy_d;

    logic [1:0] grant;
    logic       in_idle;
    logic       accept;
    logic       rsp_take;
    nzvc_t      alu_nzvc;

    assign in_idle  = (state_q == IDLE);
    assign alu_nzvc = {alu_negative, alu_zero, alu_overflow, alu_carry};

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (reset_n),
        .valid_i   ({req1_valid, req0_valid}),
        .advance_i (in_idle),
        .grant_c_o (grant)
    );

    // Grants are only offered while idle, so ready doubles as the handshake strobe.
    assign req0_ready = in_idle & grant[0];
    assign req1_ready = in_idle & grant[1];
    assign accept     = req0_ready | req1_ready;
    assign rsp_take   = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        setflags_d   = setflags_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_cntrl_d  = alu_cntrl_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        flags_d      = flags_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = grant[1];
                    if (grant[1]) begin
                        alu_a_d     = req1_a;
                        alu_b_d     = req1_b;
                        alu_cntrl_d = req1_cntrl;
                        setflags_d  = req1_setflags;
                    end else begin
                        alu_a_d     = req0_a;
                        alu_b_d     = req0_b;
                        alu_cntrl_d = req0_cntrl;
                        setflags_d  = req0_setflags;
                    end
                    busy_d  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_flags_d  = alu_nzvc;
                if (setflags_q) begin
                    flags_d = alu_nzvc;
                end
                // ALU inputs are only driven for the single execute cycle.
                alu_a_d      = '0;
                alu_b_d      = '0;
                alu_cntrl_d  = '0;
                rsp0_valid_d = ~owner_q;
                rsp1_valid_d = owner_q;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_take) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            setflags_q   <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cntrl_q  <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            flags_q      <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            setflags_q   <= setflags_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_cntrl_q  <= alu_cntrl_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            flags_q      <= flags_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_cntrl  = alu_cntrl_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign flags      = flags_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl with a behavioural 64-bit ALU hung off the ALU ports.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_ready, req0_setflags;
    logic [63:0] req0_a, req0_b;
    logic [2:0]  req0_cntrl;
    logic        req1_valid, req1_ready, req1_setflags;
    logic [63:0] req1_a, req1_b;
    logic [2:0]  req1_cntrl;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [63:0] rsp_result;
    logic [3:0]  rsp_flags, flags;
    logic [63:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_cntrl;
    logic        alu_negative, alu_zero, alu_overflow, alu_carry;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_share_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cntrl(req0_cntrl), .req0_setflags(req0_setflags),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cntrl(req1_cntrl), .req1_setflags(req1_setflags),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
        .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry(alu_carry),
        .flags(flags), .busy(busy)
    );

    // Reference ALU: carry is carry-out of a + ~b + 1 for subtract (1 means no borrow).
    always_comb begin
        logic [64:0] sum;
        sum          = '0;
        alu_overflow = 1'b0;
        alu_carry    = 1'b0;
        alu_result   = '0;
        case (alu_cntrl)
            3'b000: alu_result = alu_b;
            3'b010: begin
                sum          = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result   = sum[63:0];
                alu_carry    = sum[64];
                alu_overflow = (alu_a[63] == alu_b[63]) && (alu_result[63] != alu_a[63]);
            end
            3'b011: begin
                sum          = {1'b0, alu_a} + {1'b0, ~alu_b} + 65'd1;
                alu_result   = sum[63:0];
                alu_carry    = sum[64];
                alu_overflow = (alu_a[63] != alu_b[63]) && (alu_result[63] != alu_a[63]);
            end
            3'b100: alu_result = alu_a & alu_b;
            3'b101: alu_result = alu_a | alu_b;
            3'b110: alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
        alu_negative = alu_result[63];
        alu_zero     = (alu_result == 64'd0);
    end

    typedef struct packed {
        logic        port;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  cntrl;
        logic        sf;
        logic [63:0] exp_res;
        logic [3:0]  exp_rflags;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic p, input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] c, input logic sf);
        if (!p) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_cntrl = c; req0_setflags = sf;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_cntrl = c; req1_setflags = sf;
        end
    endtask

    task automatic run_op(input vec_t v);
        int k;
        drive(v.port, 1'b1, v.a, v.b, v.cntrl, v.sf);
        #1;
        k = 0;
        while (!(v.port ? req1_ready : req0_ready) && k < 10) begin
            @(posedge clk); #1; k++;
        end
        if (!(v.port ? req1_ready : req0_ready)) begin
            chk("accept_timeout", 64'd0, 64'd1);
            drive(v.port, 1'b0, '0, '0, '0, 1'b0);
            return;
        end
        chk("other_ready_low", 64'(v.port ? req0_ready : req1_ready), 64'd0);
        @(posedge clk); #1;
        drive(v.port, 1'b0, '0, '0, '0, 1'b0);
        chk("exec_alu_a", alu_a, v.a);
        chk("exec_alu_b", alu_b, v.b);
        chk("exec_alu_cntrl", 64'(alu_cntrl), 64'(v.cntrl));
        chk("exec_busy_ready", 64'({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid}), 64'b10000);
        @(posedge clk); #1;
        chk("resp_valids", 64'({rsp1_valid, rsp0_valid}), v.port ? 64'b10 : 64'b01);
        chk("resp_result", rsp_result, v.exp_res);
        chk("resp_flags", 64'(rsp_flags), 64'(v.exp_rflags));
        chk("arch_flags", 64'(flags), 64'(v.exp_flags));
        chk("resp_alu_idle", 64'({alu_cntrl, (alu_a == 64'd0)}), 64'b0001);
        if (v.port) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        @(posedge clk); #1;
        chk("done_idle", 64'({busy, rsp0_valid, rsp1_valid}), 64'd0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy,
                               flags, rsp_flags, alu_cntrl}), 64'd0);
        chk({nm, "_result"}, rsp_result, 64'd0);
        chk({nm, "_alu_ab"}, alu_a | alu_b, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] gseq [4];
        int         ngr;
        logic       drop;

        vecs[0] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b1, 64'h8000_0000_0000_0000, 4'b1010, 4'b1010};
        vecs[1] = '{1'b1, 64'd5, 64'd5, 3'b011, 1'b0, 64'd0, 4'b0101, 4'b1010};
        vecs[2] = '{1'b0, 64'hF0F0, 64'h0FF0, 3'b100, 1'b0, 64'h00F0, 4'b0000, 4'b1010};
        vecs[3] = '{1'b1, 64'hF0F0, 64'h0FF0, 3'b101, 1'b1, 64'hFFF0, 4'b0000, 4'b0000};
        vecs[4] = '{1'b0, 64'h123, 64'd0, 3'b000, 1'b1, 64'd0, 4'b0100, 4'b0100};
        vecs[5] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b110, 1'b0, 64'd0, 4'b0100, 4'b0100};
        vecs[6] = '{1'b1, 64'd1, 64'd2, 3'b011, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 4'b1000};
        vecs[7] = '{1'b1, 64'd9, 64'd3, 3'b111, 1'b0, 64'd0, 4'b0100, 4'b1000};

        reset_n = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_bus", 64'({busy, req0_ready, req1_ready}), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i]);
        end

        // Both requesters always valid: grants must alternate starting with requester 0.
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drive(1'b0, 1'b1, 64'd1, 64'd1, 3'b010, 1'b0);
        drive(1'b1, 1'b1, 64'd10, 64'd20, 3'b010, 1'b0);
        #1;
        ngr  = 0;
        drop = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            chk("no_dual_ready", 64'(req0_ready & req1_ready), 64'd0);
            chk("no_dual_rsp", 64'(rsp0_valid & rsp1_valid), 64'd0);
            if (rsp0_valid) chk("cont_rsp0_result", rsp_result, 64'd2);
            if (rsp1_valid) chk("cont_rsp1_result", rsp_result, 64'd30);
            if (ngr < 4 && (req0_ready || req1_ready)) begin
                gseq[ngr] = {1'b0, req1_ready};
                ngr++;
                if (ngr == 4) drop = 1'b1;
            end
            @(posedge clk); #1;
            if (drop) begin
                drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
                drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
                drop = 1'b0;
            end
        end
        chk("cont_grant_count", 64'(ngr), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("cont_grant_order", 64'(gseq[i]), 64'(i % 2));
        end
        chk("cont_drained", 64'({busy, flags}), 64'b01000);

        // Response backpressure on requester 0 while requester 1 waits; rsp1_ready is non-owner.
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        drive(1'b0, 1'b1, 64'd3, 64'd4, 3'b010, 1'b0);
        #1;
        chk("bp_accept0", 64'(req0_ready), 64'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        drive(1'b1, 1'b1, 64'd1, 64'd2, 3'b010, 1'b0);
        #1;
        chk("bp_exec_no_ready1", 64'(req1_ready), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", 64'({rsp1_valid, rsp0_valid, req1_ready}), 64'b010);
            chk("bp_hold_result", rsp_result, 64'd7);
            @(posedge clk); #1;
        end
        rsp0_ready = 1'b1;
        #1;
        chk("bp_release_no_ready1", 64'(req1_ready), 64'd0);
        @(posedge clk); #1;
        chk("bp_after_release", 64'({rsp0_valid, req1_ready}), 64'b01);
        rsp0_ready = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
        chk("bp_exec1_a", alu_a, 64'd1);
        @(posedge clk); #1;
        chk("bp_rsp1", 64'({rsp1_valid, rsp0_valid}), 64'b10);
        chk("bp_rsp1_result", rsp_result, 64'd3);
        @(posedge clk); #1;
        chk("bp_rsp1_done", 64'({busy, rsp1_valid}), 64'd0);
        rsp1_ready = 1'b0;

        // Reset asserted during EXEC drops the op and clears everything, flags included.
        rsp0_ready = 1'b1;
        drive(1'b0, 1'b1, 64'd3, 64'd4, 3'b010, 1'b1);
        #1;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        chk("rst_exec_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("rst_mid_exec");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_no_response", 64'({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready}), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        rsp0_ready = 1'b0;

        run_op(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
